serial_bus_master: RTL

Bus master and arbiter for the shared serial slave bus carrying the `slave_devices` instances. Up to NREQ on-chip requesters post an 8-bit slave address. The block grants one requester at a time with round-robin priority, shifts the address out LSB-first, clocks eight more bit-times to shift the selected slave's data byte back in, and returns it to the winner. It replaces hand-driven bus sequencing and is the single owner of the bus clock and master data line.

---
 rtl/serial_bus_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/serial_bus_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus master and its arbiter.
package serial_bus_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_READ,
    ST_DONE
  } state_t;

  // Width of a requester index / round-robin pointer (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
  import serial_bus_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]                 req,
  input  logic [ptr_width(NREQ)-1:0]      ptr,
  output logic [NREQ-1:0]                 gnt,
  output logic [ptr_width(NREQ)-1:0]      idx,
  output logic                            valid
);

  localparam int unsigned IDW = ptr_width(NREQ);

  int unsigned    cand;
  logic [IDW-1:0] cidx;

  // Scan requesters from the pointer position, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IDW'(cand);
      if (!valid && req[cidx]) begin
        valid     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/serial_bus_master.sv
// Serial bus master: arbitrates requesters, shifts out an address, reads a byte back.
module serial_bus_master
  import serial_bus_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NREQ-1:0]                 REQ,
  input  logic [8*NREQ-1:0]               ADDR,
  output logic [NREQ-1:0]                 GNT,
  output logic                            BUSY,
  output logic                            SCLK,
  output logic                            SDO,
  input  logic                            SDI,
  output logic [7:0]                      RDATA,
  output logic                            RVALID,
  output logic [ptr_width(NREQ)-1:0]      RID
);

  localparam int unsigned IDW  = ptr_width(NREQ);
  localparam int unsigned DIVW = $clog2(2 * CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_FALL = DIVW'(CLK_DIV);
  localparam logic [2:0]      BIT_LAST = 3'(FRAME_BITS - 1);

  state_t                state, state_n;
  logic [DIVW-1:0]       div, div_n;
  logic [2:0]            bitcnt, bitcnt_n;
  logic [FRAME_BITS-1:0] tx, tx_n, rx, rx_n;
  logic [IDW-1:0]        winner, winner_n, rr_ptr, rr_ptr_n;
  logic [7:0]            rdata_n;
  logic [IDW-1:0]        rid_n;
  logic                  sclk_n, sdo_n;
  logic [NREQ-1:0]       arb_gnt, win_gnt;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (REQ),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_gnt = {{(NREQ-1){1'b0}}, 1'b1} << winner;

  // Next-state, datapath next values and decoded status outputs.
  // SCLK/SDO are derived from the next state so the registered bus lines
  // line up with state/div/tx in the same cycle without decode glitches.
  always_comb begin
    state_n  = state;
    div_n    = div;
    bitcnt_n = bitcnt;
    tx_n     = tx;
    rx_n     = rx;
    winner_n = winner;
    rr_ptr_n = rr_ptr;
    rdata_n  = RDATA;
    rid_n    = RID;
    GNT      = '0;
    BUSY     = 1'b0;
    RVALID   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|REQ) state_n = ST_ARB;
      end
      ST_ARB: begin
        BUSY = 1'b1;
        GNT  = arb_gnt;
        if (arb_valid) begin
          winner_n = arb_idx;
          tx_n     = ADDR[{arb_idx, 3'b000} +: 8];
          rx_n     = '0;
          div_n    = '0;
          bitcnt_n = '0;
          state_n  = ST_ADDR;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ADDR: begin
        BUSY = 1'b1;
        GNT  = win_gnt;
        if (div == DIV_LAST) begin
          div_n    = '0;
          bitcnt_n = bitcnt + 3'd1;
          tx_n     = {1'b0, tx[FRAME_BITS-1:1]};
          if (bitcnt == BIT_LAST) state_n = ST_READ;
        end else begin
          div_n = div + 1'b1;
        end
      end
      ST_READ: begin
        BUSY = 1'b1;
        GNT  = win_gnt;
        if (div == DIV_FALL) rx_n[bitcnt] = SDI;
        if (div == DIV_LAST) begin
          div_n    = '0;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == BIT_LAST) begin
            state_n = ST_DONE;
            rdata_n = rx_n;
            rid_n   = winner;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      ST_DONE: begin
        BUSY     = 1'b1;
        GNT      = win_gnt;
        RVALID   = 1'b1;
        rr_ptr_n = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    sclk_n = !(((state_n == ST_ADDR) || (state_n == ST_READ)) && (div_n >= DIV_FALL));
    sdo_n  = (state_n == ST_ADDR) && tx_n[0];
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      div    <= '0;
      bitcnt <= '0;
      tx     <= '0;
      rx     <= '0;
      winner <= '0;
      rr_ptr <= '0;
      RDATA  <= '0;
      RID    <= '0;
      SCLK   <= 1'b1;
      SDO    <= 1'b0;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitcnt <= bitcnt_n;
      tx     <= tx_n;
      rx     <= rx_n;
      winner <= winner_n;
      rr_ptr <= rr_ptr_n;
      RDATA  <= rdata_n;
      RID    <= rid_n;
      SCLK   <= sclk_n;
      SDO    <= sdo_n;
    end
  end

endmodule
